mips_avalon_arbiter: RTL and testbench

- Two-master, one-slave Avalon-MM arbiter that shares the single memory slave between the CPU instruction-fetch port (m0) and data port (m1).
- Grants one master at a time and holds the grant for the whole transaction, including all slave waitrequest cycles.
- Round-robin fairness between the two masters.
- Watchdog aborts a transaction if the slave stalls too long.
- Sits between the MIPS core's two bus ports and the memory slave.

---
 rtl/mips_avalon_arbiter.sv | 153 +++++++++++++++
 tb/tb_mips_avalon_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_avalon_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter for the MIPS core: m0 is the
// instruction-fetch port, m1 the data port, s the shared memory slave.
// Ports: clk, rst (async, active-high); m0_*/m1_* master-side Avalon
// (address, read, write, writedata, byteenable in; waitrequest, readdata
// out); s_* slave-side Avalon; timeout pulses for one cycle on an abort.
// Round-robin grant, held for the whole transfer; a watchdog aborts a
// transfer after TIMEOUT_CYCLES stalled cycles (0 disables it).
module mips_avalon_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CTR_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1,
        ABORT
    } state_t;

    // Counter value seen on the last allowed stall cycle.
    localparam logic [CTR_WIDTH-1:0] WD_LAST =
        CTR_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [CTR_WIDTH-1:0] wd_ctr_q, wd_ctr_d;

    logic req0;
    logic req1;
    logic req_g;

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    assign req_g = (state_q == GRANT1) ? req1 : req0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wd_ctr_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wd_ctr_q     <= wd_ctr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wd_ctr_d     = wd_ctr_q;
        unique case (state_q)
            IDLE: begin
                // On a tie the master that did not win last time goes next.
                if (req0 && (!req1 || last_grant_q)) begin
                    state_d      = GRANT0;
                    last_grant_d = 1'b0;
                    wd_ctr_d     = '0;
                end else if (req1) begin
                    state_d      = GRANT1;
                    last_grant_d = 1'b1;
                    wd_ctr_d     = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (!req_g || !s_waitrequest) begin
                    state_d = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && wd_ctr_q == WD_LAST) begin
                    state_d = ABORT;
                end else begin
                    wd_ctr_d = wd_ctr_q + 1'b1;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        timeout        = 1'b0;
        m0_waitrequest = req0;
        m1_waitrequest = req1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        unique case (state_q)
            GRANT0: begin
                // Write wins if a master illegally raises both strobes.
                s_address      = m0_address;
                s_write        = m0_write;
                s_read         = m0_read & ~m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
            end
            GRANT1: begin
                s_address      = m1_address;
                s_write        = m1_write;
                s_read         = m1_read & ~m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
            end
            ABORT: begin
                // Release the stalled master with zero data.
                timeout = 1'b1;
                if (last_grant_q) begin
                    m1_waitrequest = 1'b0;
                end else begin
                    m0_waitrequest = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Bench for mips_avalon_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_mips_avalon_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m1_read, m0_write, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic        timeout;

    logic [31:0] mad [2];
    logic [31:0] mwd [2];
    logic [3:0]  mbe [2];
    logic        mrd [2];
    logic        mwr [2];

    logic [31:0] smem [8];
    logic [31:0] rmem [8];

    int own;
    int last;
    int stalls;
    bit done [2];
    bit act [2];
    int obs [$];
    int checks;
    int errors;

    always #5 clk = ~clk;

    assign m0_address    = mad[0];
    assign m1_address    = mad[1];
    assign m0_writedata  = mwd[0];
    assign m1_writedata  = mwd[1];
    assign m0_byteenable = mbe[0];
    assign m1_byteenable = mbe[1];
    assign m0_read       = mrd[0];
    assign m1_read       = mrd[1];
    assign m0_write      = mwr[0];
    assign m1_write      = mwr[1];
    assign s_readdata    = smem[s_address[4:2]];

    mips_avalon_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .CTR_WIDTH     (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m0_address    (m0_address),
        .m0_read       (m0_read),
        .m0_write      (m0_write),
        .m0_writedata  (m0_writedata),
        .m0_byteenable (m0_byteenable),
        .m0_waitrequest(m0_waitrequest),
        .m0_readdata   (m0_readdata),
        .m1_address    (m1_address),
        .m1_read       (m1_read),
        .m1_write      (m1_write),
        .m1_writedata  (m1_writedata),
        .m1_byteenable (m1_byteenable),
        .m1_waitrequest(m1_waitrequest),
        .m1_readdata   (m1_readdata),
        .s_address     (s_address),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_byteenable  (s_byteenable),
        .s_waitrequest (s_waitrequest),
        .s_readdata    (s_readdata),
        .timeout       (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // One clock: entered at a negedge with inputs driven, returns at the
    // next negedge. own: -1 idle, 0/1 master being served, 2 aborting.
    task automatic cycle();
        bit          r [2];
        logic        e_w [2];
        logic [31:0] e_rd [2];
        logic [31:0] a_rd [2];
        logic        a_w [2];
        logic [31:0] e_sa, e_wd;
        logic [3:0]  e_be;
        logic        e_sr, e_sw, e_to;
        logic        slv_wr;
        logic [31:0] wa, wdv;
        logic [3:0]  wbe;
        int          g, nxt, nlast;
        done[0] = 0;
        done[1] = 0;
        #1;
        if (rst) begin
            own = -1;
            last = 1;
            stalls = 0;
        end
        a_rd[0] = m0_readdata;
        a_rd[1] = m1_readdata;
        a_w[0]  = m0_waitrequest;
        a_w[1]  = m1_waitrequest;
        for (int i = 0; i < 2; i++) begin
            r[i]    = mrd[i] | mwr[i];
            e_w[i]  = r[i];
            e_rd[i] = '0;
        end
        e_sa = '0; e_wd = '0; e_be = '0;
        e_sr = 0; e_sw = 0; e_to = 0;
        nxt = own;
        nlast = last;
        if (own == -1) begin
            if (r[0] && r[1]) nxt = (last == 1) ? 0 : 1;
            else if (r[0]) nxt = 0;
            else if (r[1]) nxt = 1;
            if (nxt != -1) begin
                nlast = nxt;
                stalls = 0;
            end
        end else if (own == 2) begin
            e_to = 1;
            e_w[last] = 0;
            done[last] = 1;
            nxt = -1;
        end else begin
            g = own;
            e_sa = mad[g];
            e_wd = mwd[g];
            e_be = mbe[g];
            e_sw = mwr[g];
            e_sr = mrd[g] && !mwr[g];
            e_w[g] = s_waitrequest;
            e_rd[g] = s_readdata;
            if (!r[g]) begin
                nxt = -1;
            end else if (!s_waitrequest) begin
                nxt = -1;
                done[g] = 1;
                if (mwr[g])
                    rmem[mad[g][4:2]] = merge(rmem[mad[g][4:2]], mwd[g], mbe[g]);
                else
                    check("rd_data", a_rd[g], rmem[mad[g][4:2]]);
            end else begin
                stalls++;
                if (stalls == TO) nxt = 2;
            end
        end
        check("s_read", 32'(s_read), 32'(e_sr));
        check("s_write", 32'(s_write), 32'(e_sw));
        check("s_address", s_address, e_sa);
        check("s_writedata", s_writedata, e_wd);
        check("s_byteenable", 32'(s_byteenable), 32'(e_be));
        check("timeout", 32'(timeout), 32'(e_to));
        check("m0_wait", 32'(a_w[0]), 32'(e_w[0]));
        check("m1_wait", 32'(a_w[1]), 32'(e_w[1]));
        check("m0_rdata", a_rd[0], e_rd[0]);
        check("m1_rdata", a_rd[1], e_rd[1]);
        for (int i = 0; i < 2; i++)
            if (r[i] && !a_w[i]) obs.push_back(i);
        slv_wr = s_write && !s_waitrequest;
        wa  = s_address;
        wdv = s_writedata;
        wbe = s_byteenable;
        @(posedge clk);
        if (!rst) begin
            if (slv_wr) smem[wa[4:2]] = merge(smem[wa[4:2]], wdv, wbe);
            own = nxt;
            last = nlast;
        end
        @(negedge clk);
    endtask

    task automatic idle_masters();
        for (int i = 0; i < 2; i++) begin
            act[i] = 0;
            mrd[i] = 0;
            mwr[i] = 0;
            mad[i] = '0;
            mwd[i] = '0;
            mbe[i] = '0;
        end
    endtask

    task automatic do_reset();
        idle_masters();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    task automatic drive_masters(input int pct);
        bit op;
        for (int i = 0; i < 2; i++) begin
            if (!act[i] || done[i]) begin
                if ($urandom_range(99) < pct) begin
                    op = 1'($urandom_range(1));
                    act[i] = 1;
                    mrd[i] = !op;
                    mwr[i] = op;
                    mad[i] = $urandom;
                    mwd[i] = $urandom;
                    mbe[i] = 4'($urandom);
                end else begin
                    act[i] = 0;
                    mrd[i] = 0;
                    mwr[i] = 0;
                end
            end
        end
    endtask

    initial begin
        int stuck;
        checks = 0;
        errors = 0;
        own = -1;
        last = 1;
        stalls = 0;
        s_waitrequest = 0;
        for (int i = 0; i < 8; i++) begin
            smem[i] = $urandom;
            rmem[i] = smem[i];
        end
        idle_masters();
        rst = 1;
        @(negedge clk);
        mrd[0] = 1;
        #1;
        check("rst_s_read", 32'(s_read), 32'd0);
        check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("rst_m1_wait", 32'(m1_waitrequest), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        do_reset();

        // m0 read, two slave wait states
        smem[0] = 32'h12345678;
        rmem[0] = 32'h12345678;
        mrd[0] = 1;
        mad[0] = 32'h0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) mrd[0] = 0;
            s_waitrequest = (k == 1 || k == 2);
            #1;
            if (k == 0) check("tp1_idle_wait", 32'(m0_waitrequest), 32'd1);
            if (k >= 1 && k <= 3) check("tp1_s_read", 32'(s_read), 32'd1);
            if (k == 2) check("tp1_wait", 32'(m0_waitrequest), 32'd1);
            if (k == 3) begin
                check("tp1_done", 32'(m0_waitrequest), 32'd0);
                check("tp1_rdata", m0_readdata, 32'h12345678);
            end
            if (k == 4) check("tp1_idle_after", 32'(s_read), 32'd0);
            cycle();
        end

        // m1 byte-masked write held through three wait states
        smem[2] = 32'h11223344;
        rmem[2] = 32'h11223344;
        mwr[1] = 1;
        mad[1] = 32'h8;
        mwd[1] = 32'hAABBCCDD;
        mbe[1] = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            s_waitrequest = (k >= 1 && k <= 3);
            #1;
            if (k >= 1) begin
                check("tp4_addr", s_address, 32'h8);
                check("tp4_wdata", s_writedata, 32'hAABBCCDD);
                check("tp4_be", 32'(s_byteenable), 32'h3);
            end
            cycle();
        end
        mwr[1] = 0;
        mrd[1] = 1;
        s_waitrequest = 0;
        cycle();
        #1;
        check("tp4_readback", m1_readdata, 32'h1122CCDD);
        cycle();
        mrd[1] = 0;
        cycle();

        // watchdog abort with the slave stalled forever
        mrd[0] = 1;
        mad[0] = 32'h4;
        s_waitrequest = 1;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) mrd[0] = 0;
            #1;
            if (k >= 1 && k <= 4) check("to_stall", 32'(timeout), 32'd0);
            if (k == 5) begin
                check("to_pulse", 32'(timeout), 32'd1);
                check("to_m0_wait", 32'(m0_waitrequest), 32'd0);
                check("to_m0_rdata", m0_readdata, 32'd0);
                check("to_s_read", 32'(s_read), 32'd0);
            end
            cycle();
        end

        // asynchronous reset during an m1 wait state
        mrd[1] = 1;
        mad[1] = 32'hC;
        s_waitrequest = 1;
        cycle();
        cycle();
        #1;
        check("ar_s_read_before", 32'(s_read), 32'd1);
        rst = 1;
        #1;
        check("ar_s_read_async", 32'(s_read), 32'd0);
        check("ar_m1_wait", 32'(m1_waitrequest), 32'd1);
        cycle();
        rst = 0;
        mrd[0] = 1;
        mad[0] = 32'h10;
        s_waitrequest = 0;
        cycle();
        #1;
        check("ar_m0_wins", 32'(m0_waitrequest), 32'd0);
        check("ar_m1_held", 32'(m1_waitrequest), 32'd1);
        cycle();
        mrd[0] = 0;
        mrd[1] = 0;
        cycle();

        // strict alternation with both masters always requesting
        do_reset();
        obs.delete();
        drive_masters(100);
        for (int c = 0; c < 200 && obs.size() < 6; c++) begin
            s_waitrequest = ($urandom_range(2) == 0);
            cycle();
            drive_masters(100);
        end
        check("alt_bound", 32'(obs.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < obs.size(); i++)
            check("alt_order", 32'(obs[i]), 32'(i % 2));

        // random traffic, occasional long stalls to reach the watchdog
        stuck = 0;
        for (int c = 0; c < 3000; c++) begin
            drive_masters(60);
            if (stuck > 0) begin
                stuck--;
                s_waitrequest = 1;
            end else if ($urandom_range(39) == 0) begin
                stuck = 6;
                s_waitrequest = 1;
            end else begin
                s_waitrequest = ($urandom_range(2) == 0);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
